// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter slice.
package bus_arb_pkg;

  localparam int unsigned ADDR_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    RESP
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_arb_line_buf.sv
// Line buffer plus beat counter: beat-indexed load for read assembly,
// beat-indexed select for write split.
module line_buf
  import bus_arb_pkg::*;
#(
  parameter int unsigned W     = 256,
  parameter int unsigned MEM_W = 64,
  parameter int unsigned CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     line_i,
  input  logic             adv,
  input  logic             beat_we,
  input  logic [MEM_W-1:0] beat_i,
  input  logic [CW-1:0]    sel,
  output logic [CW-1:0]    beat_o,
  output logic [W-1:0]     line_nxt_o,
  output logic [MEM_W-1:0] sel_o
);

  localparam int unsigned NB = W / MEM_W;

  logic [W-1:0]  line_q, line_d;
  logic [CW-1:0] beat_q, beat_d;

  // Next line/counter: reload at grant, otherwise store the acked beat and advance.
  always_comb begin
    line_d = line_q;
    beat_d = beat_q;
    if (start) begin
      line_d = line_i;
      beat_d = '0;
    end else if (adv) begin
      if (beat_we) begin
        for (int unsigned j = 0; j < NB; j++) begin
          if (beat_q == CW'(j)) line_d[j*MEM_W +: MEM_W] = beat_i;
        end
      end
      beat_d = beat_q + CW'(1);
    end
  end

  // Beat-indexed select of the stored line.
  always_comb begin
    sel_o = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (sel == CW'(j)) sel_o = line_q[j*MEM_W +: MEM_W];
    end
  end

  // Buffer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      beat_q <= '0;
    end else begin
      line_q <= line_d;
      beat_q <= beat_d;
    end
  end

  assign beat_o     = beat_q;
  assign line_nxt_o = line_d;

endmodule

// File: rtl/bus_arb.sv
// Two-port (I-fetch / D-cache) line arbiter onto a beat-based memory port.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned I_LINE = 256,
  parameter int unsigned D_LINE = 256,
  parameter int unsigned MEM_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [I_LINE-1:0] b_data_i,
  input  logic              b_rd_i,
  output logic              b_dv_i,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [D_LINE-1:0] b_data_in,
  input  logic              b_rd,
  output logic              b_dv,
  input  logic [D_LINE-1:0] b_data_out,
  input  logic              b_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [MEM_W-1:0]  m_wdata,
  input  logic [MEM_W-1:0]  m_rdata,
  output logic              m_req,
  output logic              m_we,
  input  logic              m_ack
);

  localparam int unsigned BUF_W   = max_u(I_LINE, D_LINE);
  localparam int unsigned CW      = $clog2(BUF_W / MEM_W) + 1;
  localparam int unsigned I_BEATS = I_LINE / MEM_W;
  localparam int unsigned D_BEATS = D_LINE / MEM_W;
  localparam int unsigned BYTES   = MEM_W / 8;
  localparam logic [ADDR_W-1:0] I_MASK = ~(ADDR_W'(I_LINE / 8) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] D_MASK = ~(ADDR_W'(D_LINE / 8) - ADDR_W'(1));

  state_e              state_q, state_d;
  port_e               rr_last_q, rr_last_d;
  logic [CW-1:0]       beats_q, beats_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [MEM_W-1:0]    m_wdata_q, m_wdata_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic                b_dv_i_q, b_dv_i_d;
  logic                b_dv_q, b_dv_d;
  logic [I_LINE-1:0]   b_data_i_q, b_data_i_d;
  logic [D_LINE-1:0]   b_data_in_q, b_data_in_d;

  logic                grant_d_port;
  logic                lb_start, lb_adv, lb_we;
  logic [BUF_W-1:0]    lb_line;
  logic [BUF_W-1:0]    lb_line_nxt;
  logic [CW-1:0]       lb_beat;
  logic [MEM_W-1:0]    lb_sel;

  line_buf #(
    .W     (BUF_W),
    .MEM_W (MEM_W),
    .CW    (CW)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (lb_start),
    .line_i     (lb_line),
    .adv        (lb_adv),
    .beat_we    (lb_we),
    .beat_i     (m_rdata),
    .sel        (lb_beat + CW'(1)),
    .beat_o     (lb_beat),
    .line_nxt_o (lb_line_nxt),
    .sel_o      (lb_sel)
  );

  // FSM next-state: grant with round-robin, run the burst, pulse completion.
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    beats_d      = beats_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    b_dv_i_d     = 1'b0;
    b_dv_d       = 1'b0;
    b_data_i_d   = b_data_i_q;
    b_data_in_d  = b_data_in_q;
    lb_start     = 1'b0;
    lb_adv       = 1'b0;
    lb_we        = 1'b0;
    lb_line      = '0;
    // D wins when it is the only requester or when I was granted last.
    grant_d_port = (b_rd || b_wr) && (!b_rd_i || rr_last_q == PORT_I);

    case (state_q)
      IDLE: begin
        if (b_rd_i || b_rd || b_wr) begin
          lb_start = 1'b1;
          m_req_d  = 1'b1;
          if (grant_d_port) begin
            rr_last_d = PORT_D;
            m_addr_d  = b_addr & D_MASK;
            beats_d   = CW'(D_BEATS);
            if (b_wr) begin
              state_d   = D_WR;
              m_we_d    = 1'b1;
              lb_line   = BUF_W'(b_data_out);
              m_wdata_d = b_data_out[MEM_W-1:0];
            end else begin
              state_d = D_RD;
            end
          end else begin
            rr_last_d = PORT_I;
            m_addr_d  = b_addr_i & I_MASK;
            beats_d   = CW'(I_BEATS);
            state_d   = I_RD;
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (m_req_q && m_ack) begin
          lb_adv = 1'b1;
          lb_we  = (state_q != D_WR);
          if ((lb_beat + CW'(1)) == beats_q) begin
            // The last beat is folded into the returned line through the
            // buffer's next-value path, so dv can follow the final ack directly.
            m_req_d = 1'b0;
            m_we_d  = 1'b0;
            state_d = RESP;
            if (state_q == I_RD) begin
              b_dv_i_d   = 1'b1;
              b_data_i_d = lb_line_nxt[I_LINE-1:0];
            end else begin
              b_dv_d = 1'b1;
              if (state_q == D_RD) b_data_in_d = lb_line_nxt[D_LINE-1:0];
            end
          end else begin
            m_addr_d = m_addr_q + ADDR_W'(BYTES);
            if (state_q == D_WR) m_wdata_d = lb_sel;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_last_q   <= PORT_I;
      beats_q     <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      b_dv_i_q    <= 1'b0;
      b_dv_q      <= 1'b0;
      b_data_i_q  <= '0;
      b_data_in_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      beats_q     <= beats_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      b_dv_i_q    <= b_dv_i_d;
      b_dv_q      <= b_dv_d;
      b_data_i_q  <= b_data_i_d;
      b_data_in_q <= b_data_in_d;
    end
  end

  // Simultaneous read and write on the data port: the write is served.
  rd_wr_conflict: cover property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) && b_rd && b_wr);

  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign b_dv_i    = b_dv_i_q;
  assign b_dv      = b_dv_q;
  assign b_data_i  = b_data_i_q;
  assign b_data_in = b_data_in_q;

endmodule
